// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions, bus size codes and serialiser state encoding.
package uart_tx_pkg;

    // Word offsets, taken from byte address bits [3:2]
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVR     = 3;
    localparam int STAT_LVL_LSB = 8;

    localparam int CTRL_TXEN  = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_PAREN = 2;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } tx_state_t;

    // HB=11 falls into the word case on purpose
    function automatic logic [31:0] hb_mask(input logic [1:0] hb);
        logic [31:0] m;
        case (hb)
            HB_BYTE: m = 32'h0000_00FF;
            HB_HALF: m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous show-ahead FIFO with occupancy level; DEPTH must be a
// power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: bus decode, registers, TX FIFO and serialiser.
// Optional even-parity bit (CTRL.PAREN) is built when UART_TX_PARITY_EN is defined.
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_BUS_REQ,
    input  logic [31:0] i_BUS_ADDR,
    input  logic [31:0] i_BUS_WDATA,
    input  logic        i_BUS_WE,
    input  logic        i_BUS_RE,
    input  logic [1:0]  i_BUS_HB,
    output logic [31:0] o_BUS_RDATA,
    output logic        o_BUS_GNT,
    output logic        o_TX,
    output logic        o_IRQ
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             sel;
    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       reg_off;
    logic [31:0]      wmask;
    logic [31:0]      rd_mux;
    logic [31:0]      status_word;
    logic [31:0]      ctrl_word;
    logic             gnt_p1;
    logic [31:0]      rdata_p1;

    logic [15:0]      baud_div;
    logic             txen;
    logic             irqen;
    logic             paren;
    logic             ovr;

    logic             push;
    logic             pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    tx_state_t        state;
    tx_state_t        state_n;
    logic [15:0]      cnt;
    logic [15:0]      cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_n;
    logic [7:0]       shreg;
    logic [7:0]       sh_n;
    logic             tx_n;
    logic             tx_p1;
    logic             irq_p1;
    logic             busy;
    logic             start_ok;
    logic             par_frame;
    logic             unused_bits;

    assign sel     = (i_BUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign accept  = i_BUS_REQ & sel & ~gnt_p1;
    assign wr_en   = accept & i_BUS_WE;
    assign rd_en   = accept & i_BUS_RE & ~i_BUS_WE;
    assign reg_off = i_BUS_ADDR[3:2];
    assign wmask   = hb_mask(i_BUS_HB);
    assign push    = wr_en & (reg_off == OFF_TXDATA);

    assign unused_bits = ^{i_BUS_ADDR[1:0], i_BUS_WDATA[31:16], wmask[31:16]};

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    logic par_en_p1;
    assign par_frame = par_en_p1;
`else
    assign par_frame = 1'b0;
    assign paren     = 1'b0;
`endif

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_CLK),
        .rst   (i_RST),
        .push  (push),
        .wdata (i_BUS_WDATA[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY]  = busy;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_OVR]   = ovr;
        status_word[STAT_LVL_LSB +: LVL_W] = fifo_level;
        ctrl_word = '0;
        ctrl_word[CTRL_TXEN]  = txen;
        ctrl_word[CTRL_IRQEN] = irqen;
        ctrl_word[CTRL_PAREN] = paren;
        case (reg_off)
            OFF_STATUS:  rd_mux = status_word;
            OFF_BAUDDIV: rd_mux = {16'h0000, baud_div};
            OFF_CTRL:    rd_mux = ctrl_word;
            default:     rd_mux = '0;
        endcase
    end

    // ---- bus response stage: GNT and read data valid one cycle after accept
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            gnt_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            gnt_p1   <= accept;
            rdata_p1 <= rd_en ? rd_mux : '0;
        end
    end

    assign o_BUS_GNT   = gnt_p1;
    assign o_BUS_RDATA = rdata_p1;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            baud_div <= DEFAULT_DIV;
            txen     <= 1'b0;
            irqen    <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (wr_en && reg_off == OFF_BAUDDIV)
                baud_div <= (baud_div & ~wmask[15:0]) | (i_BUS_WDATA[15:0] & wmask[15:0]);
            if (wr_en && reg_off == OFF_CTRL) begin
                txen  <= i_BUS_WDATA[CTRL_TXEN];
                irqen <= i_BUS_WDATA[CTRL_IRQEN];
            end
            if (push && fifo_full && !pop)
                ovr <= 1'b1;
            else if (wr_en && reg_off == OFF_STATUS && i_BUS_WDATA[STAT_OVR])
                ovr <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            paren <= 1'b0;
        else if (wr_en && reg_off == OFF_CTRL)
            paren <= i_BUS_WDATA[CTRL_PAREN];
    end
`endif

    assign busy     = (state != S_IDLE);
    assign start_ok = txen & ~fifo_empty;

    // Serialiser: every state holds for baud_div+1 clocks; baud_div is re-read at each reload
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        pop     = 1'b0;
        tx_n    = 1'b1;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    state_n = S_START;
                    cnt_n   = baud_div;
                    sh_n    = fifo_rdata;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (cnt == '0) begin
                    state_n = S_DATA;
                    cnt_n   = baud_div;
                    bit_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DATA: begin
                tx_n = shreg[0];
                if (cnt == '0) begin
                    cnt_n = baud_div;
                    sh_n  = {1'b0, shreg[7:1]};
                    bit_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = par_frame ? S_PARITY : S_STOP;
`else
                        state_n = S_STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_n = par_bit;
                if (cnt == '0) begin
                    state_n = S_STOP;
                    cnt_n   = baud_div;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_n = 1'b1;
                if (cnt == '0) begin
                    // Chain straight into the next start bit so frames run back-to-back
                    if (start_ok) begin
                        pop     = 1'b1;
                        state_n = S_START;
                        cnt_n   = baud_div;
                        sh_n    = fifo_rdata;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // ---- line stage: o_TX is a registered copy of the current state's bit
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx_p1   <= 1'b1;
            irq_p1  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            tx_p1   <= tx_n;
            irq_p1  <= irqen & fifo_empty & ~busy;
        end
    end

    always_ff @(posedge i_CLK) begin
        shreg <= sh_n;
`ifdef UART_TX_PARITY_EN
        if (pop) begin
            par_bit   <= ^fifo_rdata;
            par_en_p1 <= paren;
        end
`endif
    end

    assign o_TX  = tx_p1;
    assign o_IRQ = irq_p1;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register access, framing, overrun, IRQ and reset.
module tb_uart_tx_periph;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  hb = 2'b10;
    logic [31:0] rdata;
    logic        gnt;
    logic        tx;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        tx_after;
    logic [31:0] rd;

    uart_tx_periph dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_BUS_REQ   (req),
        .i_BUS_ADDR  (addr),
        .i_BUS_WDATA (wdata),
        .i_BUS_WE    (we),
        .i_BUS_RE    (re),
        .i_BUS_HB    (hb),
        .o_BUS_RDATA (rdata),
        .o_BUS_GNT   (gnt),
        .o_TX        (tx),
        .o_IRQ       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept lands at edge N; returns at N+1 + 1ns after checking the single GNT pulse
    task automatic bus(input logic w, input logic r, input logic [3:0] off,
                       input logic [31:0] d, input logic [1:0] size, output logic [31:0] rv);
        @(negedge clk);
        req = 1'b1; we = w; re = r; addr = BASE | {28'h0, off}; wdata = d; hb = size;
        @(posedge clk); #1;
        acc_cyc = cyc;
        req = 1'b0; we = 1'b0; re = 1'b0;
        check("gnt_pulse", {31'h0, gnt}, 32'h1);
        rv = rdata;
        @(posedge clk); #1;
        tx_after = tx;
        check("gnt_drop", {31'h0, gnt}, 32'h0);
        check("rdata_idle", rdata, 32'h0);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [1:0] size);
        logic [31:0] dummy;
        bus(1'b1, 1'b0, off, d, size, dummy);
    endtask

    task automatic rdchk(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, 1'b1, off, 32'h0, 2'b10, v);
        check(tag, v, exp);
    endtask

    // Called right after a TXDATA write with BAUDDIV=3; bits[0] is the start bit
    task automatic frame(input string tag, input logic [10:0] bits, input int nbits);
        check({tag, "_idle_before"}, {31'h0, tx_after}, 32'h1);
        @(posedge clk); #1;
        check({tag, "_start_edge"}, {31'h0, tx}, 32'h0);
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            check($sformatf("%s_bit%0d", tag, i), {31'h0, tx}, {31'h0, bits[i]});
            repeat (4) @(posedge clk); #1;
        end
    endtask

    initial begin
        logic seen;
        int   k;

        // Reset values
        repeat (3) @(posedge clk); #1;
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_gnt", {31'h0, gnt}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk); rst = 1'b0;
        rdchk("rst_status", 4'h4, 32'h0000_0004);
        rdchk("rst_bauddiv", 4'h8, 32'h0000_0363);
        rdchk("rst_ctrl", 4'hC, 32'h0000_0000);
        rdchk("txdata_reads0", 4'h0, 32'h0000_0000);

        // Unselected address must not be granted
        @(negedge clk);
        req = 1'b1; re = 1'b1; addr = 32'h0000_3004;
        @(posedge clk); #1;
        req = 1'b0; re = 1'b0;
        @(posedge clk); #1;
        check("unsel_no_gnt", {31'h0, gnt}, 32'h0);

        // Bus sizing
        wr(4'h8, 32'hDEAD_BE12, 2'b00);
        rdchk("byte_write", 4'h8, 32'h0000_0312);
        wr(4'h8, 32'hABCD_0003, 2'b01);
        rdchk("half_write", 4'h8, 32'h0000_0003);
        wr(4'hC, 32'h0000_0007, 2'b10);
`ifdef UART_TX_PARITY_EN
        rdchk("ctrl_rw", 4'hC, 32'h0000_0007);
`else
        rdchk("ctrl_rw", 4'hC, 32'h0000_0003);
`endif
        wr(4'hC, 32'h0000_0001, 2'b10);

        // Single 8N1 frame of 0xA5 at 4 clocks per bit
        wr(4'h0, 32'h0000_00A5, 2'b00);
        frame("a5", {1'b0, 1'b1, 8'hA5, 1'b0}, 10);
        rdchk("after_frame", 4'h4, 32'h0000_0004);

`ifdef UART_TX_PARITY_EN
        wr(4'hC, 32'h0000_0005, 2'b10);
        wr(4'h0, 32'h0000_0007, 2'b00);
        frame("par07", {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        rdchk("after_par", 4'h4, 32'h0000_0004);
`endif

        // Overrun with TXEN clear
        wr(4'hC, 32'h0000_0000, 2'b10);
        for (int i = 0; i < 9; i++) wr(4'h0, 32'h0000_0010 + i, 2'b00);
        rdchk("ovr_status", 4'h4, 32'h0000_080A);
        wr(4'h4, 32'h0000_0008, 2'b10);
        rdchk("ovr_clear", 4'h4, 32'h0000_0802);

        // Drain at 1 clock per bit
        wr(4'h8, 32'h0000_0000, 2'b10);
        wr(4'hC, 32'h0000_0001, 2'b10);
        repeat (120) @(posedge clk); #1;
        rdchk("drained", 4'h4, 32'h0000_0004);

        // IRQ: two back-to-back frames at 2 clocks per bit
        wr(4'h8, 32'h0000_0001, 2'b10);
        wr(4'h0, 32'h0000_0055, 2'b00);
        k = acc_cyc;
        wr(4'h0, 32'h0000_00AA, 2'b00);
        wr(4'hC, 32'h0000_0003, 2'b10);
        check("irq_low_busy", {31'h0, irq}, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk); #1;
            if (irq) seen = 1'b1;
        end
        check("irq_seen", {31'h0, seen}, 32'h1);
        check("irq_latency", cyc - k, 32'd42);
        rdchk("irq_status", 4'h4, 32'h0000_0004);
        check("irq_held", {31'h0, irq}, 32'h1);
        wr(4'hC, 32'h0000_0001, 2'b10);
        check("irq_off", {31'h0, irq}, 32'h0);

        // Asynchronous reset mid-frame
        wr(4'h0, 32'h0000_0000, 2'b00);
        wr(4'h0, 32'h0000_0033, 2'b00);
        check("mid_frame_low", {31'h0, tx}, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", {31'h0, tx}, 32'h1);
        @(negedge clk); rst = 1'b0;
        rdchk("rst_fifo_flushed", 4'h4, 32'h0000_0004);
        rdchk("rst_div_again", 4'h8, 32'h0000_0363);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
